// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the FPU divide path: field layout, special
// encodings, operand classification and a leading-zero counter.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_sub;
  } fp_class_t;

  function automatic fp_class_t classify(input fp32_t a);
    fp_class_t c;
    c.is_zero = (a.exp == '0) && (a.man == '0);
    c.is_sub  = (a.exp == '0) && (a.man != '0);
    c.is_inf  = (a.exp == '1) && (a.man == '0);
    c.is_nan  = (a.exp == '1) && (a.man != '0);
    return c;
  endfunction

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_mant_div.sv
// Combinational 24-bit significand divider. Both inputs carry the hidden bit,
// so the quotient lies in (0.5, 2); 28 quotient bits cover both cases.
module fp_mant_div (
  input  logic [23:0] i_ma,
  input  logic [23:0] i_mb,
  output logic [23:0] o_mant,
  output logic        o_guard,
  output logic        o_round,
  output logic        o_sticky,
  output logic        o_lt
);

  logic [27:0] w_q;
  logic [24:0] w_rem;

  // Restoring division: the partial remainder always stays below 2*mb.
  always_comb begin
    w_rem = {1'b0, i_ma};
    w_q   = '0;
    for (int i = 27; i >= 0; i--) begin
      if (w_rem >= {1'b0, i_mb}) begin
        w_q[i] = 1'b1;
        w_rem  = w_rem - {1'b0, i_mb};
      end
      if (i != 0) w_rem = {w_rem[23:0], 1'b0};
    end
  end

  assign o_lt     = ~w_q[27];
  assign o_mant   = w_q[27] ? w_q[27:4] : w_q[26:3];
  assign o_guard  = w_q[27] ? w_q[3] : w_q[2];
  assign o_round  = w_q[27] ? w_q[2] : w_q[1];
  assign o_sticky = (w_q[27] ? |w_q[1:0] : w_q[0]) | (w_rem != '0);

endmodule

// File: rtl/fp_div.sv
// binary32 divider, one register stage. Define SUBNORMAL_EN for gradual
// underflow; otherwise subnormal inputs and results flush to signed zero.
import fp_pkg::*;

module fp_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] opd1,
  input  logic [31:0] opd2,
  output logic        out_valid,
  output logic [31:0] res,
  output logic        exp_overflow,
  output logic        nan,
  output logic        zero
);

  localparam logic signed [9:0] BIAS_S = 10'(BIAS);

  fp32_t            w_a, w_b;
  fp_class_t        w_ca, w_cb;
  logic             w_sign, w_zero_a, w_zero_b;
  logic [23:0]      w_ma, w_mb, w_q_mant, w_sig, w_sig_r;
  logic signed [9:0] w_ea, w_eb, w_e_pre, w_e_r;
  logic             w_g, w_rb, w_st, w_lt, w_rg, w_rs, w_rup, w_denorm;
  logic [24:0]      w_sum;
  logic [31:0]      w_res;
  logic             w_ovf, w_nan, w_zero;

  logic             r_out_valid, r_ovf, r_nan, r_zero;
  logic [31:0]      r_res;

  assign w_a    = opd1;
  assign w_b    = opd2;
  assign w_ca   = classify(w_a);
  assign w_cb   = classify(w_b);
  assign w_sign = w_a.sign ^ w_b.sign;

`ifdef SUBNORMAL_EN
  logic [4:0] w_lz_a, w_lz_b;
  assign w_lz_a   = lzc24({1'b0, w_a.man});
  assign w_lz_b   = lzc24({1'b0, w_b.man});
  assign w_ma     = w_ca.is_sub ? ({1'b0, w_a.man} << w_lz_a) : {1'b1, w_a.man};
  assign w_mb     = w_cb.is_sub ? ({1'b0, w_b.man} << w_lz_b) : {1'b1, w_b.man};
  assign w_ea     = w_ca.is_sub ? (10'sd1 - $signed({5'b0, w_lz_a})) : $signed({2'b0, w_a.exp});
  assign w_eb     = w_cb.is_sub ? (10'sd1 - $signed({5'b0, w_lz_b})) : $signed({2'b0, w_b.exp});
  assign w_zero_a = w_ca.is_zero;
  assign w_zero_b = w_cb.is_zero;
`else
  assign w_ma     = {1'b1, w_a.man};
  assign w_mb     = {1'b1, w_b.man};
  assign w_ea     = $signed({2'b0, w_a.exp});
  assign w_eb     = $signed({2'b0, w_b.exp});
  assign w_zero_a = w_ca.is_zero | w_ca.is_sub;
  assign w_zero_b = w_cb.is_zero | w_cb.is_sub;
`endif

  fp_mant_div u_mant_div (
    .i_ma     (w_ma),
    .i_mb     (w_mb),
    .o_mant   (w_q_mant),
    .o_guard  (w_g),
    .o_round  (w_rb),
    .o_sticky (w_st),
    .o_lt     (w_lt)
  );

  assign w_e_pre = w_ea - w_eb + BIAS_S - (w_lt ? 10'sd1 : 10'sd0);

`ifdef SUBNORMAL_EN
  logic [9:0]  w_sh_raw;
  logic [4:0]  w_sh;
  logic [25:0] w_ext, w_shf, w_mask;
  // Tiny results: shift right so the exponent field becomes 0, folding lost bits into sticky.
  assign w_denorm = (w_e_pre <= 10'sd0);
  assign w_sh_raw = 10'sd1 - w_e_pre;
  assign w_sh     = (w_sh_raw > 10'd26) ? 5'd26 : w_sh_raw[4:0];
  assign w_ext    = {w_q_mant, w_g, w_rb};
  assign w_shf    = w_ext >> w_sh;
  assign w_mask   = (26'd1 << w_sh) - 26'd1;
  assign w_sig    = w_denorm ? w_shf[25:2] : w_q_mant;
  assign w_rg     = w_denorm ? w_shf[1] : w_g;
  assign w_rs     = w_denorm ? (w_shf[0] | (|(w_ext & w_mask)) | w_st) : (w_rb | w_st);
`else
  assign w_denorm = 1'b0;
  assign w_sig    = w_q_mant;
  assign w_rg     = w_g;
  assign w_rs     = w_rb | w_st;
`endif

  assign w_rup   = w_rg & (w_rs | w_sig[0]);
  assign w_sum   = {1'b0, w_sig} + 25'(w_rup);
  assign w_sig_r = w_sum[24] ? w_sum[24:1] : w_sum[23:0];
  assign w_e_r   = w_e_pre + (w_sum[24] ? 10'sd1 : 10'sd0);

  always_comb begin
    w_res  = '0;
    w_ovf  = 1'b0;
    w_nan  = 1'b0;
    w_zero = 1'b0;
    if (w_ca.is_nan || w_cb.is_nan || (w_zero_a && w_zero_b) || (w_ca.is_inf && w_cb.is_inf)) begin
      w_res = QNAN;
      w_nan = 1'b1;
    end else if (w_ca.is_inf) begin
      w_res = POS_INF | {w_sign, 31'b0};
    end else if (w_zero_b) begin
      w_res = POS_INF | {w_sign, 31'b0};
      w_ovf = 1'b1;
    end else if (w_zero_a || w_cb.is_inf) begin
      w_res  = {w_sign, 31'b0};
      w_zero = 1'b1;
    end else if (w_denorm) begin
      // A round-up into bit 23 lands exactly on the smallest normal encoding.
      w_res  = {w_sign, 7'b0, w_sig_r[23], w_sig_r[22:0]};
      w_zero = (w_sig_r == '0);
    end else if (w_e_r >= 10'sd255) begin
      w_res = POS_INF | {w_sign, 31'b0};
      w_ovf = 1'b1;
    end else if (w_e_r <= 10'sd0) begin
      w_res  = {w_sign, 31'b0};
      w_zero = 1'b1;
    end else begin
      w_res = {w_sign, w_e_r[7:0], w_sig_r[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_ovf       <= 1'b0;
      r_nan       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_res  <= w_res;
        r_ovf  <= w_ovf;
        r_nan  <= w_nan;
        r_zero <= w_zero;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign res          = r_res;
  assign exp_overflow = r_ovf;
  assign nan          = r_nan;
  assign zero         = r_zero;

endmodule

// File: tb/tb_fp_div.sv
// Bench for fp_div: known-answer vectors through a queue scoreboard, plus
// reset, hold-on-idle, back-to-back and reset-in-flight scenarios.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] opd1 = '0;
  logic [31:0] opd2 = '0;
  logic        out_valid;
  logic [31:0] res;
  logic        exp_overflow, nan, zero;

  // flags packed as {exp_overflow, nan, zero}
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  typedef struct packed {
    logic [31:0] r;
    logic [2:0]  f;
  } exp_t;

`ifdef SUBNORMAL_EN
  localparam logic [34:0] UF_HALF = {32'h00400000, 3'b000};
  localparam logic [34:0] UF_TINY = {32'h00000001, 3'b000};
`else
  localparam logic [34:0] UF_HALF = {32'h00000000, 3'b001};
  localparam logic [34:0] UF_TINY = {32'h00000000, 3'b001};
`endif

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  fp_div dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .opd1         (opd1),
    .opd2         (opd2),
    .out_valid    (out_valid),
    .res          (res),
    .exp_overflow (exp_overflow),
    .nan          (nan),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    opd1     = 32'h40C00000;
    opd2     = 32'h40000000;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, res, exp_overflow, nan, zero} !== 36'h0) begin
      n_err++;
      $display("FAIL reset: got v=%b res=%h f=%b%b%b, want v=0 res=00000000 f=000",
               out_valid, res, exp_overflow, nan, zero);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_arith();
    vec_t t[$];
    exp_t e;
    t = '{
      {32'h40C00000, 32'h40000000, 32'h40400000, 3'b000},
      {32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000},
      {32'hBF800000, 32'h40000000, 32'hBF000000, 3'b000},
      {32'hC1200000, 32'hBF000000, 32'h41A00000, 3'b000},
      {32'h3F800000, 32'h40E00000, 32'h3E124925, 3'b000},
      {32'h3F800000, 32'h41300000, 32'h3DBA2E8C, 3'b000},
      {32'h41200000, 32'h40400000, 32'h40555555, 3'b000},
      {32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 3'b000}
    };
    foreach (t[i]) begin
      opd1 = t[i].a; opd2 = t[i].b; in_valid = 1'b1;
      sb.push_back({t[i].r, t[i].f});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      e = sb.pop_front();
      n_vec++;
      if ({out_valid, res, exp_overflow, nan, zero} !== {1'b1, e.r, e.f}) begin
        n_err++;
        $display("FAIL arith[%0d]: got v=%b res=%h f=%b%b%b, want v=1 res=%h f=%b",
                 i, out_valid, res, exp_overflow, nan, zero, e.r, e.f);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({out_valid, res, exp_overflow, nan, zero} !== {1'b0, e.r, e.f}) begin
        n_err++;
        $display("FAIL hold[%0d]: got v=%b res=%h f=%b%b%b, want v=0 res=%h f=%b",
                 i, out_valid, res, exp_overflow, nan, zero, e.r, e.f);
      end
    end
  endtask

  task automatic test_special();
    vec_t t[$];
    exp_t e;
    t = '{
      {32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 3'b100},
      {32'h3F800000, 32'h00000000, 32'h7F800000, 3'b100},
      {32'hBF800000, 32'h80000000, 32'h7F800000, 3'b100},
      {32'h00000000, 32'h00000000, 32'h7FC00000, 3'b010},
      {32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b010},
      {32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b010},
      {32'h3F800000, 32'h7F800001, 32'h7FC00000, 3'b010},
      {32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000},
      {32'h80000000, 32'h40A00000, 32'h80000000, 3'b001},
      {32'h3F800000, 32'hFF800000, 32'h80000000, 3'b001},
      {32'h00800000, 32'h3F800000, 32'h00800000, 3'b000},
      {32'h00800000, 32'h40000000, UF_HALF},
      {32'h00000001, 32'h3F800000, UF_TINY}
    };
    foreach (t[i]) begin
      opd1 = t[i].a; opd2 = t[i].b; in_valid = 1'b1;
      sb.push_back({t[i].r, t[i].f});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      e = sb.pop_front();
      n_vec++;
      if ({out_valid, res, exp_overflow, nan, zero} !== {1'b1, e.r, e.f}) begin
        n_err++;
        $display("FAIL special[%0d] %h/%h: got v=%b res=%h f=%b%b%b, want v=1 res=%h f=%b",
                 i, t[i].a, t[i].b, out_valid, res, exp_overflow, nan, zero, e.r, e.f);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t t[$];
    exp_t e;
    t = '{
      {32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000},
      {32'h40400000, 32'h3F800000, 32'h40400000, 3'b000},
      {32'hC0000000, 32'h40800000, 32'hBF000000, 3'b000},
      {32'h40C00000, 32'h40000000, 32'h40400000, 3'b000}
    };
    opd1 = t[0].a; opd2 = t[0].b; in_valid = 1'b1;
    sb.push_back({t[0].r, t[0].f});
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_vec++;
      if ({out_valid, res, exp_overflow, nan, zero} !== {1'b1, e.r, e.f}) begin
        n_err++;
        $display("FAIL b2b[%0d]: got v=%b res=%h f=%b%b%b, want v=1 res=%h f=%b",
                 i - 1, out_valid, res, exp_overflow, nan, zero, e.r, e.f);
      end
      if (i < 3) begin
        opd1 = t[i].a; opd2 = t[i].b;
        sb.push_back({t[i].r, t[i].f});
      end else begin
        rst_n = 1'b0;
        opd1  = 32'h7F7FFFFF; opd2 = 32'h3E800000;
      end
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, res, exp_overflow, nan, zero} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_inflight: got v=%b res=%h f=%b%b%b, want v=0 res=00000000 f=000",
               out_valid, res, exp_overflow, nan, zero);
    end
    rst_n = 1'b1;
    opd1 = t[3].a; opd2 = t[3].b;
    sb.push_back({t[3].r, t[3].f});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if ({out_valid, res, exp_overflow, nan, zero} !== {1'b1, e.r, e.f}) begin
      n_err++;
      $display("FAIL resume: got v=%b res=%h f=%b%b%b, want v=1 res=%h f=%b",
               out_valid, res, exp_overflow, nan, zero, e.r, e.f);
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, want finish", $time);
    $fatal(1);
  end

endmodule
